// File: rtl/sw_req_arbiter.sv
// Round-robin arbiter sharing the LED display among 8 switch requesters.
// Ports: clk, rst(async low), sw[7:0] req, btn[0] release -> gnt/gnt_idx/gnt_vld/ledr.
module sw_req_arbiter #(
  parameter int HOLD     = 16,
  parameter int SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic [4:0]  btn,
  output logic [7:0]  gnt,
  output logic [2:0]  gnt_idx,
  output logic        gnt_vld,
  output logic [15:0] ledr
);

  localparam int CW = $clog2(HOLD) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t state, state_n;

  logic [7:0]          sw_sync [SYNC_STG];
  logic [SYNC_STG-1:0] rel_sync;
  logic                s_rel_d;
  logic [7:0]          s_req;
  logic                s_rel;
  logic                rel_pulse;

  logic [2:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    gnt_n;
  logic [2:0]    idx_n;
  logic          vld_n;
  logic [2:0]    win;
  logic          end_g;
  logic          unused_btn;

  assign unused_btn = ^btn[4:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STG; i++)
        sw_sync[i] <= '0;
      rel_sync <= '0;
      s_rel_d  <= 1'b0;
    end else begin
      sw_sync[0] <= sw;
      for (int i = 1; i < SYNC_STG; i++)
        sw_sync[i] <= sw_sync[i-1];
      rel_sync <= {rel_sync[SYNC_STG-2:0], btn[0]};
      s_rel_d  <= rel_sync[SYNC_STG-1];
    end
  end

  assign s_req     = sw_sync[SYNC_STG-1];
  assign s_rel     = rel_sync[SYNC_STG-1];
  assign rel_pulse = s_rel & ~s_rel_d;

  // Scan downward so the closest requester at or after ptr wins last.
  always_comb begin
    win = ptr;
    for (int k = 7; k >= 0; k--)
      if (s_req[ptr + 3'(k)])
        win = ptr + 3'(k);
  end

  assign end_g = ~s_req[gnt_idx] | rel_pulse |
                 ((cnt == '0) && |(s_req & ~gnt));

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    vld_n   = gnt_vld;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (|s_req) begin
          gnt_n   = 8'b1 << win;
          idx_n   = win;
          vld_n   = 1'b1;
          cnt_n   = CNT_INIT;
          state_n = GRANT;
        end else begin
          gnt_n = '0;
          idx_n = '0;
          vld_n = 1'b0;
        end
      end
      GRANT: begin
        if (end_g) begin
          gnt_n   = '0;
          idx_n   = '0;
          vld_n   = 1'b0;
          ptr_n   = gnt_idx + 3'd1;
          state_n = IDLE;
        end else begin
          cnt_n = (cnt == '0) ? '0 : cnt - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      gnt_vld <= vld_n;
    end
  end

  assign ledr = {gnt_vld, 4'b0, gnt_idx, gnt};

endmodule

// File: tb/tb_sw_req_arbiter.sv
// Randomized bench for sw_req_arbiter against a tenure-age reference model.
// Drives sw/btn/rst, compares gnt, gnt_idx, gnt_vld, ledr every cycle.
module tb_sw_req_arbiter;

  localparam int HD = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw;
  logic [4:0]  btn;
  logic [7:0]  gnt;
  logic [2:0]  gnt_idx;
  logic        gnt_vld;
  logic [15:0] ledr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_swh [SS+1];
  logic       m_bh  [SS+1];
  bit         m_vld;
  int         m_idx;
  int         m_ptr;
  int         m_age;

  sw_req_arbiter #(.HOLD(HD), .SYNC_STG(SS)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .ledr(ledr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i <= SS; i++) begin
      m_swh[i] = '0;
      m_bh[i]  = 1'b0;
    end
    m_vld = 0;
    m_idx = 0;
    m_ptr = 0;
    m_age = 0;
  endtask

  // One clock edge of the reference: requests are seen SS edges late,
  // release is the rising edge of the delayed button.
  task automatic m_step();
    logic [7:0] req;
    bit pulse, fin;
    int w;
    req   = m_swh[SS-1];
    pulse = m_bh[SS-1] && !m_bh[SS];
    if (!m_vld) begin
      if (req != 0) begin
        w = -1;
        for (int k = 0; k < 8; k++)
          if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
        m_vld = 1;
        m_idx = w;
        m_age = 0;
      end
    end else begin
      fin = !req[m_idx] || pulse ||
            (m_age >= HD - 1 && (req & ~(8'd1 << m_idx)) != 0);
      if (fin) begin
        m_vld = 0;
        m_ptr = (m_idx + 1) % 8;
      end else begin
        m_age++;
      end
    end
    for (int i = SS; i > 0; i--) begin
      m_swh[i] = m_swh[i-1];
      m_bh[i]  = m_bh[i-1];
    end
    m_swh[0] = sw;
    m_bh[0]  = btn[0];
  endtask

  task automatic cmp_all();
    logic [7:0] eg;
    logic [2:0] ei;
    eg = m_vld ? (8'd1 << m_idx) : 8'd0;
    ei = m_vld ? 3'(m_idx) : 3'd0;
    chk("gnt", {8'h0, gnt}, {8'h0, eg});
    chk("gnt_idx", {13'h0, gnt_idx}, {13'h0, ei});
    chk("gnt_vld", {15'h0, gnt_vld}, {15'h0, m_vld});
    chk("ledr", ledr, {m_vld, 4'b0, ei, eg});
    chk("onehot", {15'h0, $countones(gnt) <= 1}, 16'h1);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    cmp_all();
  endtask

  task automatic async_rst();
    rst = 1'b0;
    #1;
    m_reset();
    chk("rst_ledr", ledr, 16'h0000);
    chk("rst_gnt", {8'h0, gnt}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    sw  = 8'hFF;
    btn = '0;
    m_reset();
    #1;
    chk("t1_ledr", ledr, 16'h0000);
    chk("t1_vld", {15'h0, gnt_vld}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t1_idle1", ledr, 16'h0000);
    tick();
    chk("t1_idle2", ledr, 16'h0000);
    repeat (20) tick();

    async_rst();
    sw = 8'h00;
    repeat (3) tick();
    sw = 8'h10;
    repeat (3) tick();
    chk("t2_ledr", ledr, 16'h8410);
    repeat (8) tick();
    chk("t2_held", {8'h0, gnt}, 16'h0010);

    sw = 8'h81;
    repeat (30) tick();

    sw = 8'h04;
    repeat (4) tick();
    sw = 8'h0C;
    repeat (2) tick();
    sw = 8'h18;
    repeat (10) tick();

    sw = 8'h01;
    repeat (3) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_hold", {8'h0, gnt}, 16'h0001);
    end
    btn[0] = 1'b1;
    tick();
    btn[0] = 1'b0;
    tick();
    tick();
    chk("t5_rel", {8'h0, gnt}, 16'h0000);
    tick();
    chk("t5_regrant", {8'h0, gnt}, 16'h0001);
    repeat (3) tick();

    sw = 8'h0C;
    repeat (6) tick();
    async_rst();
    repeat (3) tick();
    chk("t6_first", {8'h0, gnt}, 16'h0004);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) sw = 8'($urandom);
      if ($urandom_range(9) == 0) btn[0] = ~btn[0];
      btn[4:1] = 4'($urandom);
      if ($urandom_range(299) == 0) async_rst();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
